// File: rtl/alu_flags_seq.sv
// ---------------------------------------------------------------------------
// alu_flags_seq
//
// Registers the {N,Z,C,V} condition flags produced alongside an ALU result,
// evaluates a 4-bit condition code against the registered flags, and keeps
// a sticky overflow bit plus a saturating count of registered overflows.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous, active-high reset
//   valid_in     in   operand/result bundle valid this cycle
//   flag_we      in   flag write enable (qualifies valid_in)
//   alu_control  in   2  00 add, 01 sub, 10 AND, 11 OR
//   a, b         in   WIDTH  original operands (b not pre-inverted for sub)
//   result       in   WIDTH  ALU result selected by alu_control
//   cout         in   adder carry-out
//   cond         in   4  condition code evaluated against flags_q
//   clr_sticky   in   synchronous clear of sticky_v and ov_count
//   flags_q      out  4  registered flags {N,Z,C,V}, bit 3 = N
//   valid_out    out  one-cycle pulse after each accepted update
//   cond_pass    out  cond evaluated against flags_q (combinational)
//   sticky_v     out  sticky overflow
//   ov_count     out  CNT_W  saturating count of registered V=1 events
//
// Handshake: an update is accepted at a rising edge whenever
// valid_in & flag_we is high; there is no backpressure, so every such edge
// loads new flags and valid_out pulses for exactly one cycle afterwards.
// ---------------------------------------------------------------------------
module alu_flags_seq #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic             flag_we,
    input  logic [1:0]       alu_control,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] result,
    input  logic             cout,
    input  logic [3:0]       cond,
    input  logic             clr_sticky,
    output logic [3:0]       flags_q,
    output logic             valid_out,
    output logic             cond_pass,
    output logic             sticky_v,
    output logic [CNT_W-1:0] ov_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic       w_accept;
    logic       w_is_arith;
    logic       w_n;
    logic       w_z;
    logic       w_c;
    logic       w_v;
    logic [3:0] r_flags;
    logic       r_valid;
    logic       r_sticky;
    logic [CNT_W-1:0] r_ov_count;

    assign w_accept   = valid_in & flag_we;
    assign w_is_arith = ~alu_control[1];

    // Next-flag values. For sub, alu_control[0] flips b's sign so the same
    // "operands agree in sign, result disagrees" overflow test covers both
    // add and sub; logic ops force C and V low.
    assign w_n = result[WIDTH-1];
    assign w_z = (result == '0);
    assign w_c = w_is_arith & cout;
    assign w_v = w_is_arith
               & ~(a[WIDTH-1] ^ b[WIDTH-1] ^ alu_control[0])
               & (a[WIDTH-1] ^ result[WIDTH-1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flags <= 4'b0000;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_accept;
            if (w_accept) begin
                r_flags <= {w_n, w_z, w_c, w_v};
            end
        end
    end

    // A registered overflow outranks a simultaneous clear: the clear is
    // applied first and the new event then counts as the first one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sticky   <= 1'b0;
            r_ov_count <= '0;
        end else if (w_accept && w_v) begin
            r_sticky <= 1'b1;
            if (clr_sticky) begin
                r_ov_count <= CNT_ONE;
            end else if (r_ov_count != CNT_MAX) begin
                r_ov_count <= r_ov_count + CNT_ONE;
            end
        end else if (clr_sticky) begin
            r_sticky   <= 1'b0;
            r_ov_count <= '0;
        end
    end

    // Condition evaluation against the registered flags.
    always_comb begin
        logic f_n;
        logic f_z;
        logic f_c;
        logic f_v;
        f_n = r_flags[3];
        f_z = r_flags[2];
        f_c = r_flags[1];
        f_v = r_flags[0];
        cond_pass = 1'b1;
        case (cond)
            4'b0000: cond_pass = f_z;
            4'b0001: cond_pass = ~f_z;
            4'b0010: cond_pass = f_c;
            4'b0011: cond_pass = ~f_c;
            4'b0100: cond_pass = f_n;
            4'b0101: cond_pass = ~f_n;
            4'b0110: cond_pass = f_v;
            4'b0111: cond_pass = ~f_v;
            4'b1000: cond_pass = f_c & ~f_z;
            4'b1001: cond_pass = ~f_c | f_z;
            4'b1010: cond_pass = (f_n == f_v);
            4'b1011: cond_pass = (f_n != f_v);
            4'b1100: cond_pass = ~f_z & (f_n == f_v);
            4'b1101: cond_pass = f_z | (f_n != f_v);
            default: cond_pass = 1'b1;
        endcase
    end

    assign flags_q   = r_flags;
    assign valid_out = r_valid;
    assign sticky_v  = r_sticky;
    assign ov_count  = r_ov_count;

endmodule

// File: tb/tb_alu_flags_seq.sv
// ---------------------------------------------------------------------------
// Testbench for alu_flags_seq. Two instances share all inputs: one with the
// default counter width and one with CNT_W=2 to reach counter saturation.
// ---------------------------------------------------------------------------
module tb_alu_flags_seq;

    logic       clk;
    logic       rst;
    logic       valid_in;
    logic       flag_we;
    logic [1:0] alu_control;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] result;
    logic       cout;
    logic [3:0] cond;
    logic       clr_sticky;

    logic [3:0] flags_q;
    logic       valid_out;
    logic       cond_pass;
    logic       sticky_v;
    logic [7:0] ov_count;

    logic [3:0] flags_q2;
    logic       valid_out2;
    logic       cond_pass2;
    logic       sticky_v2;
    logic [1:0] ov_count2;

    int n_checks = 0;
    int n_fail   = 0;

    alu_flags_seq #(.WIDTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .flag_we(flag_we),
        .alu_control(alu_control), .a(a), .b(b), .result(result),
        .cout(cout), .cond(cond), .clr_sticky(clr_sticky),
        .flags_q(flags_q), .valid_out(valid_out), .cond_pass(cond_pass),
        .sticky_v(sticky_v), .ov_count(ov_count)
    );

    alu_flags_seq #(.WIDTH(4), .CNT_W(2)) dut_c2 (
        .clk(clk), .rst(rst), .valid_in(valid_in), .flag_we(flag_we),
        .alu_control(alu_control), .a(a), .b(b), .result(result),
        .cout(cout), .cond(cond), .clr_sticky(clr_sticky),
        .flags_q(flags_q2), .valid_out(valid_out2), .cond_pass(cond_pass2),
        .sticky_v(sticky_v2), .ov_count(ov_count2)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // Computes the true ALU outcome using integer arithmetic; flags come from
    // mathematical definitions (signed range, unsigned carry/no-borrow).
    function automatic int to_signed4(input int v);
        return (v >= 8) ? v - 16 : v;
    endfunction

    task automatic ref_alu(input int ctl, input int ia, input int ib,
                           output logic [3:0] res, output logic co,
                           output logic [3:0] flags);
        int sum;
        int sres;
        logic n, z, c, v;
        c = 1'b0;
        v = 1'b0;
        co = 1'($urandom_range(0, 1));
        case (ctl)
            0: begin
                sum  = ia + ib;
                res  = 4'(sum);
                co   = (sum > 15);
                c    = co;
                sres = to_signed4(ia) + to_signed4(ib);
                v    = (sres > 7) || (sres < -8);
            end
            1: begin
                res  = 4'(ia - ib);
                co   = (ia >= ib); // carry out of a + ~b + 1 means no borrow
                c    = co;
                sres = to_signed4(ia) - to_signed4(ib);
                v    = (sres > 7) || (sres < -8);
            end
            2: res = 4'(ia & ib);
            default: res = 4'(ia | ib);
        endcase
        n = res[3];
        z = (res == 4'd0);
        flags = {n, z, c, v};
    endtask

    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;          // unsigned higher
            4'd9:  return !cy || z;          // unsigned lower or same
            4'd10: return n == v;            // signed >=
            4'd11: return n != v;            // signed <
            4'd12: return !z && (n == v);    // signed >
            4'd13: return z || (n != v);     // signed <=
            default: return 1'b1;
        endcase
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input logic [1:0] ctl, input logic [3:0] ia, input logic [3:0] ib,
                         input logic [3:0] ires, input logic ic,
                         input logic ivin, input logic iwe, input logic iclr);
        alu_control = ctl;
        a           = ia;
        b           = ib;
        result      = ires;
        cout        = ic;
        valid_in    = ivin;
        flag_we     = iwe;
        clr_sticky  = iclr;
        @(posedge clk);
        #1;
        valid_in   = 1'b0;
        flag_we    = 1'b0;
        clr_sticky = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst = 1'b1;
        #1;
        n_checks++; if (flags_q !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b required %b", flags_q, 4'b0000); end
        n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b required 0", valid_out); end
        n_checks++; if (sticky_v !== 1'b0) begin n_fail++; $display("FAIL reset_sticky: got %b required 0", sticky_v); end
        n_checks++; if (ov_count !== 8'd0) begin n_fail++; $display("FAIL reset_count: got %0d required 0", ov_count); end
        cond = 4'b0001; #1;
        n_checks++; if (cond_pass !== 1'b1) begin n_fail++; $display("FAIL reset_cond_ne: got %b required 1", cond_pass); end
        cond = 4'b0000; #1;
        n_checks++; if (cond_pass !== 1'b0) begin n_fail++; $display("FAIL reset_cond_eq: got %b required 0", cond_pass); end
        // An update presented during reset must be discarded.
        valid_in = 1'b1; flag_we = 1'b1; alu_control = 2'b00;
        a = 4'b0111; b = 4'b0001; result = 4'b1000; cout = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (flags_q !== 4'b0000) begin n_fail++; $display("FAIL reset_update_ignored: got %b required 0000", flags_q); end
        valid_in = 1'b0; flag_we = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_add_overflow;
        drive(2'b00, 4'b0111, 4'b0001, 4'b1000, 1'b0, 1'b1, 1'b1, 1'b0);
        n_checks++; if (flags_q !== 4'b1001) begin n_fail++; $display("FAIL add_flags: got %b required 1001", flags_q); end
        n_checks++; if (valid_out !== 1'b1) begin n_fail++; $display("FAIL add_valid: got %b required 1", valid_out); end
        n_checks++; if (sticky_v !== 1'b1) begin n_fail++; $display("FAIL add_sticky: got %b required 1", sticky_v); end
        n_checks++; if (ov_count !== 8'd1) begin n_fail++; $display("FAIL add_count: got %0d required 1", ov_count); end
    endtask

    task automatic test_hold;
        drive(2'b00, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
        n_checks++; if (flags_q !== 4'b1001) begin n_fail++; $display("FAIL hold_flags: got %b required 1001", flags_q); end
        n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL hold_valid: got %b required 0", valid_out); end
        // flag_we alone does not qualify an update either
        drive(2'b00, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
        n_checks++; if (flags_q !== 4'b1001) begin n_fail++; $display("FAIL hold_we_only: got %b required 1001", flags_q); end
    endtask

    task automatic test_sub_cond;
        drive(2'b01, 4'b0011, 4'b0011, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0);
        n_checks++; if (flags_q !== 4'b0110) begin n_fail++; $display("FAIL sub_flags: got %b required 0110", flags_q); end
        cond = 4'b0000; #1;
        n_checks++; if (cond_pass !== 1'b1) begin n_fail++; $display("FAIL sub_cond_eq: got %b required 1", cond_pass); end
        cond = 4'b1000; #1;
        n_checks++; if (cond_pass !== 1'b0) begin n_fail++; $display("FAIL sub_cond_hi: got %b required 0", cond_pass); end
        cond = 4'b1001; #1;
        n_checks++; if (cond_pass !== 1'b1) begin n_fail++; $display("FAIL sub_cond_ls: got %b required 1", cond_pass); end
    endtask

    task automatic test_logic;
        drive(2'b10, 4'b1000, 4'b1000, 4'b1000, 1'b1, 1'b1, 1'b1, 1'b0);
        n_checks++; if (flags_q !== 4'b1000) begin n_fail++; $display("FAIL logic_flags: got %b required 1000", flags_q); end
    endtask

    task automatic test_async_reset;
        drive(2'b00, 4'b0111, 4'b0001, 4'b1000, 1'b0, 1'b1, 1'b1, 1'b0);
        #2;
        rst = 1'b1;   // mid-cycle, well before the next rising edge
        #1;
        n_checks++; if (flags_q !== 4'b0000) begin n_fail++; $display("FAIL async_flags: got %b required 0000", flags_q); end
        n_checks++; if (sticky_v !== 1'b0) begin n_fail++; $display("FAIL async_sticky: got %b required 0", sticky_v); end
        n_checks++; if (ov_count !== 8'd0) begin n_fail++; $display("FAIL async_count: got %0d required 0", ov_count); end
        valid_in = 1'b1; flag_we = 1'b1; alu_control = 2'b01;
        a = 4'b0011; b = 4'b0011; result = 4'b0000; cout = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (flags_q !== 4'b0000) begin n_fail++; $display("FAIL async_update_ignored: got %b required 0000", flags_q); end
        n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL async_valid: got %b required 0", valid_out); end
        @(negedge clk);
        rst = 1'b0;
        drive(2'b01, 4'b0011, 4'b0011, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0);
        n_checks++; if (flags_q !== 4'b0110) begin n_fail++; $display("FAIL async_first_update: got %b required 0110", flags_q); end
    endtask

    task automatic test_saturation;
        logic [1:0] exp2 [4] = '{2'd1, 2'd2, 2'd3, 2'd3};
        drive(2'b00, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++; if (ov_count2 !== 2'd0 || sticky_v2 !== 1'b0) begin n_fail++; $display("FAIL sat_clear: got count %0d sticky %b required 0 0", ov_count2, sticky_v2); end
        for (int i = 0; i < 4; i++) begin
            drive(2'b00, 4'b0111, 4'b0001, 4'b1000, 1'b0, 1'b1, 1'b1, 1'b0);
            n_checks++; if (ov_count2 !== exp2[i]) begin n_fail++; $display("FAIL sat_count_%0d: got %0d required %0d", i, ov_count2, exp2[i]); end
        end
        n_checks++; if (ov_count !== 8'd4) begin n_fail++; $display("FAIL sat_wide_count: got %0d required 4", ov_count); end
        // clear alongside an overflow update: the new event survives the clear
        drive(2'b01, 4'b1000, 4'b0001, 4'b0111, 1'b1, 1'b1, 1'b1, 1'b1);
        n_checks++; if (ov_count2 !== 2'd1) begin n_fail++; $display("FAIL sat_clr_set_count: got %0d required 1", ov_count2); end
        n_checks++; if (sticky_v2 !== 1'b1) begin n_fail++; $display("FAIL sat_clr_set_sticky: got %b required 1", sticky_v2); end
        n_checks++; if (flags_q2 !== 4'b0011) begin n_fail++; $display("FAIL sat_clr_set_flags: got %b required 0011", flags_q2); end
        // clear alone leaves the flags untouched
        drive(2'b00, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++; if (ov_count !== 8'd0 || sticky_v !== 1'b0) begin n_fail++; $display("FAIL clr_only: got count %0d sticky %b required 0 0", ov_count, sticky_v); end
        n_checks++; if (flags_q !== 4'b0011) begin n_fail++; $display("FAIL clr_keeps_flags: got %b required 0011", flags_q); end
    endtask

    task automatic test_back_to_back;
        logic [1:0] ctl_t [4] = '{2'b00, 2'b01, 2'b11, 2'b01};
        logic [3:0] a_t   [4] = '{4'b0010, 4'b0001, 4'b0000, 4'b1000};
        logic [3:0] b_t   [4] = '{4'b0011, 4'b0010, 4'b0000, 4'b0001};
        logic [3:0] r_t   [4] = '{4'b0101, 4'b1111, 4'b0000, 4'b0111};
        logic       c_t   [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [3:0] f_t   [4] = '{4'b0000, 4'b1000, 4'b0100, 4'b0011};
        for (int i = 0; i < 4; i++) begin
            alu_control = ctl_t[i]; a = a_t[i]; b = b_t[i]; result = r_t[i]; cout = c_t[i];
            valid_in = 1'b1; flag_we = 1'b1; clr_sticky = 1'b0;
            @(posedge clk); #1;
            n_checks++; if (flags_q !== f_t[i] || valid_out !== 1'b1) begin n_fail++; $display("FAIL b2b_%0d: got flags %b valid %b required %b 1", i, flags_q, valid_out, f_t[i]); end
        end
        valid_in = 1'b0; flag_we = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL b2b_valid_drop: got %b required 0", valid_out); end
    endtask

    task automatic test_random;
        logic [3:0] m_flags;
        logic       m_sticky;
        int         m_cnt;
        int         m_cnt2;
        logic       m_valid;
        logic [3:0] nf;
        logic [3:0] res;
        logic       co;
        int         ctl, ia, ib;
        logic       vin, we, clr, acc;
        // restart from a known state
        @(negedge clk); rst = 1'b1; #1; rst = 1'b0;
        m_flags = 4'b0000; m_sticky = 1'b0; m_cnt = 0; m_cnt2 = 0;
        for (int i = 0; i < 300; i++) begin
            ctl = $urandom_range(0, 3);
            ia  = $urandom_range(0, 15);
            ib  = $urandom_range(0, 15);
            ref_alu(ctl, ia, ib, res, co, nf);
            vin = ($urandom_range(0, 3) != 0);
            we  = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 7) == 0);
            cond = 4'($urandom_range(0, 15));
            drive(2'(ctl), 4'(ia), 4'(ib), res, co, vin, we, clr);
            acc = vin && we;
            m_valid = acc;
            if (acc) m_flags = nf;
            if (acc && nf[0]) begin
                m_sticky = 1'b1;
                m_cnt  = clr ? 1 : ((m_cnt  < 255) ? m_cnt  + 1 : 255);
                m_cnt2 = clr ? 1 : ((m_cnt2 < 3)   ? m_cnt2 + 1 : 3);
            end else if (clr) begin
                m_sticky = 1'b0; m_cnt = 0; m_cnt2 = 0;
            end
            n_checks++; if (flags_q !== m_flags) begin n_fail++; $display("FAIL rnd_flags[%0d]: got %b required %b", i, flags_q, m_flags); end
            n_checks++; if (valid_out !== m_valid) begin n_fail++; $display("FAIL rnd_valid[%0d]: got %b required %b", i, valid_out, m_valid); end
            n_checks++; if (cond_pass !== ref_cond(cond, m_flags)) begin n_fail++; $display("FAIL rnd_cond[%0d]: cond %b got %b required %b", i, cond, cond_pass, ref_cond(cond, m_flags)); end
            n_checks++; if (sticky_v !== m_sticky || sticky_v2 !== m_sticky) begin n_fail++; $display("FAIL rnd_sticky[%0d]: got %b/%b required %b", i, sticky_v, sticky_v2, m_sticky); end
            n_checks++; if (ov_count !== 8'(m_cnt)) begin n_fail++; $display("FAIL rnd_count[%0d]: got %0d required %0d", i, ov_count, m_cnt); end
            n_checks++; if (ov_count2 !== 2'(m_cnt2)) begin n_fail++; $display("FAIL rnd_count2[%0d]: got %0d required %0d", i, ov_count2, m_cnt2); end
        end
    endtask

    // ---------------- sequence & report ----------------
    initial begin
        rst = 1'b1; valid_in = 1'b0; flag_we = 1'b0; alu_control = 2'b00;
        a = 4'd0; b = 4'd0; result = 4'd0; cout = 1'b0; cond = 4'd0; clr_sticky = 1'b0;
        test_reset();
        test_add_overflow();
        test_hold();
        test_sub_cond();
        test_logic();
        test_async_reset();
        test_saturation();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_flags_seq.md
ALU_FLAGS_SEQ -- requirements
Module: alu_flags_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 4: operand/result width in bits, legal range 2..64.
REQ-002 SHALL have parameter CNT_W, default 8: overflow event counter width in bits, minimum 1.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 valid_in  in  1  operand/result bundle valid this cycle.
REQ-006 flag_we  in  1  flag write enable; qualifies valid_in.
REQ-007 alu_control  in  2  00 add, 01 sub, 10 AND, 11 OR.
REQ-008 a, b  in  WIDTH each  original ALU operands (b not pre-inverted for sub).
REQ-009 result  in  WIDTH  final ALU result selected by alu_control.
REQ-010 cout  in  1  adder carry-out.
REQ-011 cond  in  4  condition code to evaluate against the registered flags.
REQ-012 clr_sticky  in  1  synchronous clear of sticky_v and ov_count.
REQ-013 flags_q  out  4  registered flags {N,Z,C,V}, bit 3 = N.
REQ-014 valid_out  out  1  asserted one cycle after an accepted update.
REQ-015 cond_pass  out  1  cond evaluated against flags_q.
REQ-016 sticky_v  out  1  sticky overflow, set by any registered V=1.
REQ-017 ov_count  out  CNT_W  saturating count of registered V=1 events.

Function
REQ-018 Next-flag values SHALL be computed combinationally from the current inputs: N = result[WIDTH-1]; Z = 1 iff result is all zero; C = ~alu_control[1] & cout; V = ~alu_control[1] & ~(a[WIDTH-1] ^ b[WIDTH-1] ^ alu_control[0]) & (a[WIDTH-1] ^ result[WIDTH-1]).
REQ-019 For logic ops (alu_control[1]=1), C and V SHALL be 0.
REQ-020 An update is accepted when valid_in & flag_we = 1 at a rising edge; flags_q SHALL load the next-flag values at that edge (latency 1 cycle).
REQ-021 When no update is accepted, flags_q SHALL hold its value.
REQ-022 valid_out SHALL equal the registered value of (valid_in & flag_we); high for exactly one cycle per accepted update.
REQ-023 cond_pass SHALL be combinational from cond and flags_q: 0000 Z; 0001 ~Z; 0010 C; 0011 ~C; 0100 N; 0101 ~N; 0110 V; 0111 ~V; 1000 C&~Z; 1001 ~C|Z; 1010 N==V; 1011 N!=V; 1100 ~Z&(N==V); 1101 Z|(N!=V); 1110, 1111 always 1.
REQ-024 On an accepted update with next V=1, sticky_v SHALL set to 1 and ov_count SHALL increment by 1, saturating at 2^CNT_W-1 (no wrap).
REQ-025 clr_sticky=1 SHALL clear sticky_v and ov_count to 0 at the next edge.
REQ-026 Simultaneous clr_sticky and accepted V=1 update: set wins; sticky_v=1, ov_count=1.
REQ-027 flags_q update and clr_sticky are independent; clr_sticky SHALL NOT modify flags_q.
REQ-028 Back-to-back accepted updates SHALL each be registered; no bubbles required, no backpressure exists.

Reset
REQ-029 rst=1 SHALL immediately, without waiting for a clock edge, force flags_q=0000, valid_out=0, sticky_v=0, ov_count=0.
REQ-030 An update presented while rst=1 SHALL be discarded; the first accepted update is the first rising edge with rst=0.
REQ-031 cond_pass during reset SHALL reflect flags_q=0000 (e.g. cond=0001 -> 1, cond=0000 -> 0).

Verification
REQ-032 WIDTH=4 add: a=0111, b=0001, result=1000, cout=0, ctl=00, valid_in=flag_we=1 -> next cycle flags_q=1001, valid_out=1, sticky_v=1, ov_count=1.
REQ-033 Sub: a=0011, b=0011, result=0000, cout=1, ctl=01 -> flags_q=0110; cond=0000 -> cond_pass=1; cond=1000 -> 0; cond=1001 -> 1.
REQ-034 Hold: valid_in=1, flag_we=0, result=0000 after REQ-032 -> flags_q stays 1001, valid_out=0.
REQ-035 Logic: ctl=10, a=1000, b=1000, result=1000, cout=1 -> flags_q=1000 (C=0, V=0); CNT_W=2, four overflow updates -> ov_count=11 after 3rd and 4th; clr_sticky with a concurrent V=1 update -> ov_count=01, sticky_v=1.
REQ-036 Async reset: assert rst between clock edges after REQ-032 -> flags_q=0000, sticky_v=0, ov_count=0 before next edge; update during rst ignored.
